// File: rtl/poly5_sdiv_seq_32s_16s.sv
// Iterative radix-2 restoring signed divider, 32s / 16s -> quotient + remainder, start/done handshake with ce stall.
// Optional divide-by-zero flag port `dbz` enabled by defining POLY5_SDIV_DBZ_FLAG_EN.
module poly5_sdiv_seq_32s_16s #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = 32,
  parameter int          din1_WIDTH = 16,
  parameter int          dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem
`ifdef POLY5_SDIV_DBZ_FLAG_EN
  ,
  output logic                  dbz
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(din0_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB first while quotient bits shift in at the LSB.
  logic [din0_WIDTH-1:0] dvd_q, dvd_d;
  logic [din1_WIDTH-1:0] prem_q, prem_d;
  logic [din1_WIDTH:0]   dsr_q, dsr_d;
  logic [din1_WIDTH-1:0] dvdLo_q, dvdLo_d;
  logic                  sq_q, sq_d;
  logic                  sr_q, sr_d;
  logic                  zero_q, zero_d;
  logic [dout_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;

  logic [din1_WIDTH:0]   trial;
  logic                  fits;
  logic [din1_WIDTH:0]   dsrExt;

  assign trial  = {prem_q, dvd_q[din0_WIDTH-1]};
  assign fits   = (trial >= dsr_q);
  assign dsrExt = {din1[din1_WIDTH-1], din1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    dsr_d   = dsr_q;
    dvdLo_d = dvdLo_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Unsigned magnitudes hold -2^31 and -2^15 exactly.
          dvd_d   = din0[din0_WIDTH-1] ? ({din0_WIDTH{1'b0}} - din0) : din0;
          dsr_d   = din1[din1_WIDTH-1] ? ({(din1_WIDTH+1){1'b0}} - dsrExt) : dsrExt;
          dvdLo_d = din0[din1_WIDTH-1:0];
          sq_d    = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
          sr_d    = din0[din0_WIDTH-1];
          zero_d  = (din1 == '0);
          prem_d  = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        prem_d = fits ? din1_WIDTH'(trial - dsr_q) : trial[din1_WIDTH-1:0];
        dvd_d  = {dvd_q[din0_WIDTH-2:0], fits};
        if (cnt_q == CW'(din0_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        if (zero_q) begin
          quot_d = '1;
          rem_d  = dvdLo_q;
        end else begin
          quot_d = sq_q ? ({din0_WIDTH{1'b0}} - dvd_q) : dvd_q;
          rem_d  = sr_q ? ({din1_WIDTH{1'b0}} - prem_q) : prem_q;
        end
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over ce; ce low freezes everything including the done/dbz pulse.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      dvdLo_q <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      dvdLo_q <= dvdLo_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign quot = quot_q;
  assign rem  = rem_q;

`ifdef POLY5_SDIV_DBZ_FLAG_EN
  assign dbz = (state_q == DONE) & zero_q;
`endif

endmodule

// File: tb/tb_poly5_sdiv_seq_32s_16s.sv
// Self-checking bench for poly5_sdiv_seq_32s_16s: table vectors, scoreboard queue, hand-written corner sequences.
module tb_poly5_sdiv_seq_32s_16s;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ce;
  logic        start;
  logic [31:0] din0;
  logic [15:0] din1;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [15:0] rem;
`ifdef POLY5_SDIV_DBZ_FLAG_EN
  logic        dbz;
`endif

  poly5_sdiv_seq_32s_16s dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .ce     (ce),
    .start  (start),
    .din0   (din0),
    .din1   (din1),
    .busy   (busy),
    .done   (done),
    .quot   (quot),
    .rem    (rem)
`ifdef POLY5_SDIV_DBZ_FLAG_EN
    ,
    .dbz    (dbz)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  exp_t scoreQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // C-style truncating division reference, widened to 64 bits so -2^31/-1 cannot trap.
  function automatic void refDiv(input logic [31:0] a, input logic [15:0] b,
                                 output logic [31:0] q, output logic [15:0] r);
    longint sa, sd, lq, lr;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    if (sd == 0) begin
      q = '1;
      r = a[15:0];
    end else begin
      lq = sa / sd;
      lr = sa - lq * sd;
      q  = lq[31:0];
      r  = lr[15:0];
    end
  endfunction

  task automatic pulseReset();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [15:0] b,
                               input logic [31:0] q, input logic [15:0] r, input bit push);
    exp_t e;
    if (push) begin
      e.q = q;
      e.r = r;
      e.z = (b == 16'h0000);
      scoreQ.push_back(e);
    end
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, counting sampled cycles from the first busy cycle, then pops the scoreboard.
  task automatic checkOutput(input string name, input int expLat, input int stallAt,
                             input bit junk, input bit holdDone);
    int          cyc;
    int          busyCycles;
    exp_t        e;
    logic [31:0] heldQ;
    cyc        = 1;
    busyCycles = busy ? 1 : 0;
    while (!done && cyc < expLat + 20) begin
      if (cyc == stallAt) ce = 1'b0;
      if (cyc == stallAt + 5) ce = 1'b1;
      if (junk && (cyc == 5 || cyc == 20)) begin
        din0  = 32'h7FFF_0001;
        din1  = 16'h0003;
        start = 1'b1;
      end
      if (junk && (cyc == 6 || cyc == 21)) start = 1'b0;
      @(posedge ap_clk);
      #1;
      cyc++;
      if (busy) busyCycles++;
    end
    if (!done) begin
      check({name, " done_timeout"}, 64'(done), 64'd1);
      ce    = 1'b1;
      start = 1'b0;
      if (scoreQ.size() > 0) void'(scoreQ.pop_front());
      pulseReset();
      return;
    end
    check({name, " latency"}, 64'(cyc), 64'(expLat));
    check({name, " busy_cycles"}, 64'(busyCycles), 64'(expLat));
    if (scoreQ.size() == 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s scoreboard: got done with no pending result, want pending result", name);
    end else begin
      e = scoreQ.pop_front();
      check({name, " quot"}, 64'(quot), 64'(e.q));
      check({name, " rem"}, 64'(rem), 64'(e.r));
`ifdef POLY5_SDIV_DBZ_FLAG_EN
      check({name, " dbz"}, 64'(dbz), 64'(e.z));
`endif
    end
    if (holdDone) begin
      heldQ = quot;
      ce    = 1'b0;
      repeat (3) begin
        @(posedge ap_clk);
        #1;
      end
      check({name, " done_held"}, 64'(done), 64'd1);
      check({name, " quot_held"}, 64'(quot), 64'(heldQ));
      ce = 1'b1;
    end
    if (junk) start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    check({name, " idle_busy"}, 64'(busy), 64'd0);
    check({name, " idle_done"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] ra, rq;
    logic [15:0] rb, rr;
    int          sawDone;

    vecs[0]  = '{32'd100,        16'd7,      32'd14,         16'd2};
    vecs[1]  = '{-32'sd100,      16'd7,      -32'sd14,       -16'sd2};
    vecs[2]  = '{32'd100,        -16'sd7,    -32'sd14,       16'd2};
    vecs[3]  = '{-32'sd100,      -16'sd7,    32'd14,         -16'sd2};
    vecs[4]  = '{32'd0,          -16'sd5,    32'd0,          16'd0};
    vecs[5]  = '{32'd1234,       16'd0,      32'hFFFF_FFFF,  16'h04D2};
    vecs[6]  = '{32'h8000_0000,  16'hFFFF,   32'h8000_0000,  16'd0};
    vecs[7]  = '{32'h8000_0000,  16'h8000,   32'd65536,      16'd0};
    vecs[8]  = '{32'h7FFF_FFFF,  16'h7FFF,   32'd65538,      16'd1};
    vecs[9]  = '{32'd7,          16'd100,    32'd0,          16'd7};
    vecs[10] = '{-32'sd100,      16'd0,      32'hFFFF_FFFF,  16'hFF9C};
    vecs[11] = '{32'h8000_0000,  16'd1,      32'h8000_0000,  16'd0};

    ap_rst = 1'b1;
    ce     = 1'b1;
    start  = 1'b0;
    din0   = '0;
    din1   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quot", 64'(quot), 64'd0);
    check("reset rem", 64'(rem), 64'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b1);
      checkOutput($sformatf("vec%0d", i), 34, -1, 1'b0, 1'b0);
    end

    // Five ce-low cycles in the middle of CALC stretch latency to 39.
    applyStimulus(32'd100, 16'd7, 32'd14, 16'd2, 1'b1);
    checkOutput("stall_calc", 39, 10, 1'b0, 1'b0);

    // ce low while in DONE keeps the done pulse and results frozen.
    applyStimulus(-32'sd100, 16'd7, -32'sd14, -16'sd2, 1'b1);
    checkOutput("stall_done", 34, -1, 1'b0, 1'b1);

    // Starts during busy and during DONE must be ignored.
    applyStimulus(32'd100, -16'sd7, -32'sd14, 16'd2, 1'b1);
    checkOutput("start_busy", 34, -1, 1'b1, 1'b0);

    // Reset at cycle 10 with ce low: abort, clear outputs, never pulse done.
    applyStimulus(32'd5000, 16'd3, 32'd0, 16'd0, 1'b0);
    repeat (9) begin
      @(posedge ap_clk);
      #1;
    end
    ap_rst = 1'b1;
    ce     = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    ce     = 1'b1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort quot", 64'(quot), 64'd0);
    check("abort rem", 64'(rem), 64'd0);
    sawDone = 0;
    repeat (40) begin
      @(posedge ap_clk);
      #1;
      if (done) sawDone = 1;
    end
    check("abort no_done", 64'(sawDone), 64'd0);
    applyStimulus(32'd1000, 16'd9, 32'd111, 16'd1, 1'b1);
    checkOutput("after_abort", 34, -1, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = 16'($urandom);
      if (i % 10 == 0) rb = 16'h0000;
      if (i % 10 == 1) rb = 16'hFFFF;
      if (i % 10 == 2) ra = 32'h8000_0000;
      if (i % 10 == 3) rb = 16'($urandom_range(1, 15));
      refDiv(ra, rb, rq, rr);
      applyStimulus(ra, rb, rq, rr, 1'b1);
      checkOutput($sformatf("rand%0d", i), 34, -1, 1'b0, 1'b0);
    end

    check("scoreboard drained", 64'(scoreQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
